// File: rtl/sha256_block_seq.sv
// rtl/sha256_block_seq.sv - SHA-256 multi-block sequencer with Davies-Meyer feed-forward
// Feeds one 512-bit block at a time to the round pipeline and accumulates the chaining state.
`timescale 1ns/1ps
module sha256_block_seq #(
  parameter int MAX_BLKS = 20,
  parameter int MSG_W    = 10240,
  localparam int CW      = $clog2(MAX_BLKS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MSG_W-1:0] msg_in,
  input  logic [CW-1:0]    blk_cnt,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic [511:0]     blk_w,
  output logic [255:0]     blk_h,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [255:0]     res_state,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic [255:0]     digest,
  output logic             err
);

  localparam int AW = $clog2(MSG_W);
  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state;
  logic [MSG_W-1:0] msg_reg;
  logic [CW-1:0]    n_reg;
  logic [CW-1:0]    idx;
  logic [255:0]     h_reg;
  logic [255:0]     sum;
  logic [CW-1:0]    off;
  logic [AW-1:0]    base;

  // Blocks are issued most-significant first, so block idx sits N-1-idx slots up.
  always_comb begin
    off  = n_reg - idx - CW'(1);
    base = AW'(off) << 9;
  end

  assign blk_w = msg_reg[base +: 512];
  assign blk_h = h_reg;

  // Word-wise feed-forward; no carries cross 32-bit word boundaries.
  always_comb begin
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      sum[i*32 +: 32] = h_reg[i*32 +: 32] + res_state[i*32 +: 32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      blk_valid <= 1'b0;
      res_ready <= 1'b0;
      dig_valid <= 1'b0;
      err       <= 1'b0;
      h_reg     <= IV;
      idx       <= '0;
      n_reg     <= '0;
      msg_reg   <= '0;
      digest    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            msg_reg  <= msg_in;
            n_reg    <= blk_cnt;
            h_reg    <= IV;
            idx      <= '0;
            in_ready <= 1'b0;
            if (blk_cnt != '0 && blk_cnt <= CW'(MAX_BLKS)) begin
              blk_valid <= 1'b1;
              state     <= ISSUE;
            end else begin
              err       <= 1'b1;
              digest    <= IV;
              dig_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        ISSUE: begin
          if (blk_ready) begin
            blk_valid <= 1'b0;
            res_ready <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (res_valid) begin
            h_reg     <= sum;
            idx       <= idx + CW'(1);
            res_ready <= 1'b0;
            if (idx == n_reg - CW'(1)) begin
              digest    <= sum;
              dig_valid <= 1'b1;
              state     <= DONE;
            end else begin
              blk_valid <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        DONE: begin
          if (dig_ready) begin
            dig_valid <= 1'b0;
            err       <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_seq.sv
// tb/tb_sha256_block_seq.sv - scoreboard bench for sha256_block_seq
// A stub round pipeline answers each block; a SHA-256 reference predicts blocks and digests.
`timescale 1ns/1ps
module tb_sha256_block_seq;

  localparam int MAX_BLKS = 20;
  localparam int MSG_W    = MAX_BLKS * 512;
  localparam int CW       = $clog2(MAX_BLKS + 1);
  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] ABC_DIG = {
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [MSG_W-1:0] msg_in = '0;
  logic [CW-1:0]    blk_cnt = '0;
  logic             blk_valid;
  logic             blk_ready = 1'b1;
  logic [511:0]     blk_w;
  logic [255:0]     blk_h;
  logic             res_valid = 1'b0;
  logic             res_ready;
  logic [255:0]     res_state = '0;
  logic             dig_valid;
  logic             dig_ready = 1'b1;
  logic [255:0]     digest;
  logic             err;

  always #5 clk = ~clk;

  sha256_block_seq #(.MAX_BLKS(MAX_BLKS), .MSG_W(MSG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .msg_in(msg_in), .blk_cnt(blk_cnt),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_w(blk_w), .blk_h(blk_h),
    .res_valid(res_valid), .res_ready(res_ready), .res_state(res_state),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .digest(digest), .err(err)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int mode = 0;      // stub behaviour: 0 zero result, 1 echo blk_h, 2 real 64 rounds
  int epoch = 0;     // bumped on every mid-run reset so the stub can abandon its block
  int blk_seen = 0;
  logic [767:0] blk_q[$];
  logic [256:0] dig_q[$];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = a[i*32 +: 32] + b[i*32 +: 32];
    return r;
  endfunction

  function automatic logic [255:0] rounds(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a, b, c, d, e, f, g, h};
  endfunction

  function automatic logic [255:0] stub_result(input int md, input logic [255:0] hin, input logic [511:0] blk);
    if (md == 0) return '0;
    if (md == 1) return hin;
    return rounds(hin, blk);
  endfunction

  // Reference: walk the blocks from the top of the message, chaining H through feed-forward.
  task automatic expect_blocks(input logic [MSG_W-1:0] m, input int n, output logic [255:0] dg);
    logic [255:0] hh;
    logic [511:0] w;
    hh = IV;
    for (int k = 0; k < n; k++) begin
      w = m[(n-1-k)*512 +: 512];
      blk_q.push_back({w, hh});
      hh = add8(hh, stub_result(mode, hh, w));
    end
    dg = hh;
  endtask

  task automatic send(input logic [MSG_W-1:0] m, input int c);
    int k;
    @(posedge clk);
    #1 in_valid = 1'b1; msg_in = m; blk_cnt = CW'(c);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 2000);
    if (!in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL in_handshake_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (dig_q.size() != 0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (dig_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL digest_timeout: %0d digests outstanding, required 0", dig_q.size());
      dig_q.delete();
      blk_q.delete();
    end
    @(posedge clk);
  endtask

  task automatic check_idle(input string name);
    check(name, 256'({in_ready, blk_valid, res_ready, dig_valid, err}), 256'(5'b10000));
  endtask

  task automatic rand_msg(output logic [MSG_W-1:0] m);
    for (int j = 0; j < MSG_W/32; j++) m[j*32 +: 32] = $urandom();
  endtask

  // Block monitor: every issued block must match the next predicted {blk_w, blk_h}.
  initial begin
    logic [767:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && blk_valid) blk_seen++;
      if (rst_n && blk_valid && blk_ready) begin
        if (blk_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_block: blk_w %h issued, required none", blk_w);
        end else begin
          e = blk_q.pop_front();
          check("blk_w_hi", 256'(blk_w[511:256]), e[767:512]);
          check("blk_w_lo", 256'(blk_w[255:0]), e[511:256]);
          check("blk_h", blk_h, e[255:0]);
        end
      end
    end
  end

  // Digest monitor.
  initial begin
    logic [256:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && dig_valid && dig_ready) begin
        if (dig_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_digest: %h presented, required none", digest);
        end else begin
          e = dig_q.pop_front();
          check("digest", digest, e[255:0]);
          check("err", 256'(err), 256'(e[256]));
        end
      end
    end
  end

  // Stub round pipeline with random latency; a reset leaves its result dangling for a few cycles.
  initial begin
    logic [255:0] r;
    int ep, lat, k;
    forever begin
      @(negedge clk);
      if (rst_n && blk_valid && blk_ready) begin
        r = stub_result(mode, blk_h, blk_w);
        ep = epoch;
        lat = $urandom_range(0, 3);
        @(posedge clk);
        repeat (lat) @(posedge clk);
        #1 res_valid = 1'b1; res_state = r;
        k = 0;
        forever begin
          @(negedge clk);
          if (epoch != ep) begin
            repeat (3) @(posedge clk);
            break;
          end
          if (res_ready) break;
          k++;
          if (k > 2000) begin
            n_cmp++; n_fail++;
            $display("FAIL res_handshake_timeout: res_ready stayed 0, required 1");
            break;
          end
        end
        @(posedge clk);
        #1 res_valid = 1'b0;
      end
    end
  end

  initial begin
    logic [MSG_W-1:0] m;
    logic [255:0] dg;
    logic [511:0] abc_blk;
    int s, n;
    abc_blk = {32'h61626380, 416'h0, 64'h18};

    repeat (2) @(negedge clk);
    check_idle("reset_outputs");
    check("reset_digest", digest, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle("idle_hold");
    end

    // One block, zero result: digest is IV.
    mode = 0; rand_msg(m);
    expect_blocks(m, 1, dg);
    dig_q.push_back({1'b0, IV});
    send(m, 1); wait_done();

    // Two blocks, echo stub: H doubles each block.
    mode = 1; rand_msg(m);
    expect_blocks(m, 2, dg);
    dig_q.push_back({1'b0, dg});
    send(m, 2); wait_done();

    // Block backpressure.
    @(posedge clk); #1 blk_ready = 1'b0;
    mode = 1; rand_msg(m);
    expect_blocks(m, 3, dg);
    dig_q.push_back({1'b0, dg});
    send(m, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_blk_valid", 256'(blk_valid), 256'(1));
      check("stall_blk_w", 256'(blk_w[511:256] ^ blk_w[255:0]), 256'(m[1535:1280] ^ m[1279:1024]));
      check("stall_blk_h", blk_h, IV);
    end
    @(posedge clk); #1 blk_ready = 1'b1;
    wait_done();

    // Digest backpressure.
    @(posedge clk); #1 dig_ready = 1'b0;
    mode = 0; rand_msg(m);
    expect_blocks(m, 1, dg);
    dig_q.push_back({1'b0, IV});
    send(m, 1);
    s = 0;
    while (!dig_valid && s < 100) begin
      @(negedge clk);
      s++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_dig", digest, IV);
      check("stall_flags", 256'({dig_valid, in_ready}), 256'(2'b10));
    end
    @(posedge clk); #1 dig_ready = 1'b1;
    wait_done();

    // Illegal block counts.
    for (int t = 0; t < 2; t++) begin
      n = (t == 0) ? 0 : MAX_BLKS + 1;
      rand_msg(m);
      s = blk_seen;
      dig_q.push_back({1'b1, IV});
      send(m, n); wait_done();
      check("illegal_no_block", 256'(blk_seen - s), 256'(0));
    end

    // Random messages, including a full-width one.
    for (int t = 0; t < 6; t++) begin
      mode = $urandom_range(0, 2);
      n = (t == 0) ? MAX_BLKS : $urandom_range(1, MAX_BLKS);
      rand_msg(m);
      expect_blocks(m, n, dg);
      dig_q.push_back({1'b0, dg});
      send(m, n); wait_done();
    end

    // Real compression of padded "abc".
    mode = 2; m = '0; m[511:0] = abc_blk;
    expect_blocks(m, 1, dg);
    dig_q.push_back({1'b0, ABC_DIG});
    send(m, 1); wait_done();

    // Reset while waiting on a result, then stale res_valid in IDLE, then "abc" again.
    mode = 2; rand_msg(m);
    expect_blocks(m, 3, dg);
    dig_q.push_back({1'b0, dg});
    send(m, 3);
    s = 0;
    while (!res_ready && s < 100) begin
      @(negedge clk);
      s++;
    end
    @(posedge clk);
    #1 rst_n = 1'b0; epoch++;
    @(negedge clk);
    check_idle("midrun_reset_outputs");
    blk_q.delete(); dig_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle("stale_res_ignored");
    end
    m = '0; m[511:0] = abc_blk;
    expect_blocks(m, 1, dg);
    dig_q.push_back({1'b0, ABC_DIG});
    send(m, 1); wait_done();

    check("blk_q_drained", 256'(blk_q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_block_seq.md
Name: sha256_block_seq

Overview:
- Sits between `padding` and the 64-round compression pipeline built from `w_comp` and `hash256` stages.
- Accepts one padded message of up to MAX_BLKS 512-bit blocks.
- Issues the blocks one at a time, each with the current chaining state.
- Adds each 64-round result into the chaining state (Davies–Meyer feed-forward) and emits the final 256-bit digest.
- Only one block is outstanding at a time, because block k+1 depends on block k.

Parameters:
- MAX_BLKS, 20, maximum number of 512-bit blocks per message.
- MSG_W, 10240, message input width; must equal MAX_BLKS*512.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  padded message valid.
- in_ready  out  1  block can accept a message.
- msg_in  in  MSG_W  padded message, right-aligned; the last block is msg_in[511:0].
- blk_cnt  in  $clog2(MAX_BLKS+1)  number of blocks N in msg_in.
- blk_valid  out  1  block and chaining state valid toward the round pipeline.
- blk_ready  in  1  round pipeline accepts the block.
- blk_w  out  512  current block; W0 = blk_w[511:480].
- blk_h  out  256  current chaining state {a,b,c,d,e,f,g,h}, a at MSBs.
- res_valid  in  1  64-round result valid.
- res_ready  out  1  block accepts the result.
- res_state  in  256  {a..h} after round 63.
- dig_valid  out  1  digest valid.
- dig_ready  in  1  downstream accepts the digest.
- digest  out  256  final H0..H7, H0 at MSBs.
- err  out  1  message had an illegal blk_cnt; qualified by dig_valid.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state IDLE;
  - in_ready=1, blk_valid=0, res_ready=0, dig_valid=0, err=0;
  - H = IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19);
  - block index idx=0;
  - msg register and digest cleared to 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1 (in_ready is high only in IDLE).
  - On in_valid&&in_ready: capture msg_in and blk_cnt into registers; load H=IV; set idx=0.
  - If 1<=blk_cnt<=MAX_BLKS, go to ISSUE. Otherwise set err=1, set digest=IV, and go to DONE; no block is issued.
- ISSUE:
  - blk_valid=1.
  - blk_w = msg_reg[(N-1-idx)*512 +: 512], so the first issued block is the most significant used block.
  - blk_h = H.
  - On blk_valid&&blk_ready, go to WAIT; blk_valid falls the next cycle.
  - blk_w and blk_h hold stable while blk_valid=1 and blk_ready=0.
- WAIT:
  - res_ready=1, blk_valid=0.
  - On res_valid&&res_ready, each H[i] <= H[i] + res_state word i, mod 2^32 with no carry between words; idx <= idx+1.
  - If idx==N-1, go to DONE and register digest from the updated sum. Otherwise go to ISSUE.
  - The next blk_valid rises the cycle after the result handshake.
- res_valid while not in WAIT is ignored: res_ready=0 and no state change.
- DONE:
  - dig_valid=1; digest and err are held stable until dig_valid&&dig_ready.
  - On that handshake go to IDLE, dig_valid=0, err=0 the next cycle.
  - A new message cannot be accepted in the same cycle as the digest handshake.
- Latency:
  - in handshake -> first blk_valid: 1 cycle.
  - Last res handshake -> dig_valid: 1 cycle.
  - Sequencer overhead: 1 cycle per block plus the round-pipeline latency.
- Reset mid-operation:
  - Everything returns to reset values immediately; the in-flight block is abandoned.
  - The bench must flush the round pipeline; a stale res_valid is ignored because it arrives outside WAIT.
- Width rules:
  - All additions are 32-bit wraparound.
  - The blk_cnt comparison is unsigned.
  - blk_cnt == MAX_BLKS uses the whole of msg_in.

Test Plan:
- Reset then idle, all inputs 0: in_ready=1, blk_valid=res_ready=dig_valid=err=0, and no state change for 10 cycles.
- blk_cnt=1, stub returns res_state=0: blk_w=msg_in[511:0] and blk_h=IV; digest = IV (6a09e667…5be0cd19); err=0.
- blk_cnt=2, stub echoes res_state=blk_h:
  - first blk_w=msg_in[1023:512] with blk_h=IV;
  - second blk_w=msg_in[511:0] with blk_h=2*IV (word0 d413ccce);
  - digest=4*IV (word0 a827999c).
- Backpressure:
  - Hold blk_ready=0 for 5 cycles: blk_valid, blk_w and blk_h stay stable.
  - Hold dig_ready=0 for 5 cycles: digest stays stable; in_ready=0 throughout.
- Illegal counts:
  - blk_cnt=0: err=1 with dig_valid=1, digest=IV, blk_valid never asserted.
  - blk_cnt=21: same response.
- Full compression model, padded "abc" (blk_cnt=1): digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Reset mid-operation: assert rst_n=0 during WAIT of a 3-block message, then send "abc" → the "abc" digest above; a stale res_valid injected in IDLE has no effect.
